// File: rtl/kbd_arb_pkg.sv
// Shared constants, arbiter state type and case-folding helper for the keyboard source arbiter.
package kbd_arb_pkg;

  localparam int unsigned SRC_PS2  = 0;
  localparam int unsigned SRC_UART = 1;
  localparam int unsigned NUM_SRC  = 2;
  localparam int unsigned ASCII_W  = 7;

  typedef enum logic {
    ST_IDLE,
    ST_HOLD
  } arb_state_t;

  // Lower-case letters a..z become A..Z by clearing bit 5; everything else passes.
  function automatic logic [ASCII_W-1:0] upcase(input logic [ASCII_W-1:0] c);
    return ((c >= 7'h61) && (c <= 7'h7A)) ? (c & 7'h5F) : c;
  endfunction

endpackage

// File: rtl/kbd_fifo.sv
// Per-source character FIFO, 2**FIFO_AW entries deep, with extra-MSB pointers.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module kbd_fifo
  import kbd_arb_pkg::*;
#(
  parameter int unsigned FIFO_AW = 2
) (
  input  logic               clk25,
  input  logic               rst,
  input  logic               i_flush,
  input  logic               i_push,
  input  logic [ASCII_W-1:0] i_data,
  input  logic               i_pop,
  output logic [ASCII_W-1:0] o_data,
  output logic               o_full,
  output logic               o_empty
);

  logic [FIFO_AW:0]   r_wr_ptr;
  logic [FIFO_AW:0]   r_rd_ptr;
  logic [ASCII_W-1:0] r_mem [2**FIFO_AW];
  logic               w_do_push;
  logic               w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]) &&
                     (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]);
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_data    = r_mem[r_rd_ptr[FIFO_AW-1:0]];

  always_ff @(posedge clk25) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Full-and-popping writes the slot being read; the read sees the old value this cycle.
  always_ff @(posedge clk25) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr[FIFO_AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/kbd_source_arbiter.sv
// Merges PS/2 and UART character streams into the PIA keyboard register (round robin).
// Optional KBD_UPCASE_EN folds a..z to A..Z at the FIFO inputs.
module kbd_source_arbiter
  import kbd_arb_pkg::*;
#(
  parameter int unsigned FIFO_AW = 2
) (
  input  logic               clk25,
  input  logic               rst,
  input  logic [7:0]         ps2_data,
  input  logic               ps2_valid,
  input  logic [7:0]         uart_data,
  input  logic               uart_valid,
  input  logic [1:0]         src_en,
  input  logic               kbd_rd,
  input  logic               ovf_clr,
  output logic [ASCII_W-1:0] kbd_data,
  output logic               kbd_ready,
  output logic [1:0]         ovf
);

  arb_state_t         r_state;
  arb_state_t         w_state_nxt;
  logic [ASCII_W-1:0] r_kbd_data;
  logic               r_last;
  logic [NUM_SRC-1:0] r_ovf;

  logic [NUM_SRC-1:0] w_push, w_pop, w_full, w_empty, w_avail, w_ovf_set;
  logic [ASCII_W-1:0] w_in  [NUM_SRC];
  logic [ASCII_W-1:0] w_out [NUM_SRC];
  logic               w_load;
  logic               w_win;
  logic               w_unused_msb;

  assign w_unused_msb = ps2_data[7] ^ uart_data[7];

`ifdef KBD_UPCASE_EN
  assign w_in[SRC_PS2]  = upcase(ps2_data[ASCII_W-1:0]);
  assign w_in[SRC_UART] = upcase(uart_data[ASCII_W-1:0]);
`else
  assign w_in[SRC_PS2]  = ps2_data[ASCII_W-1:0];
  assign w_in[SRC_UART] = uart_data[ASCII_W-1:0];
`endif

  assign w_push    = {uart_valid, ps2_valid} & src_en;
  assign w_avail   = ~w_empty & src_en;
  assign w_ovf_set = w_push & w_full & ~w_pop;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    kbd_fifo #(
      .FIFO_AW(FIFO_AW)
    ) u_fifo (
      .clk25  (clk25),
      .rst    (rst),
      .i_flush(~src_en[g]),
      .i_push (w_push[g]),
      .i_data (w_in[g]),
      .i_pop  (w_pop[g]),
      .o_data (w_out[g]),
      .o_full (w_full[g]),
      .o_empty(w_empty[g])
    );
  end

  // A disabled source is never eligible, so a flush can't race a grant.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = '0;
    w_load      = 1'b0;
    w_win       = r_last;
    case (r_state)
      ST_IDLE: begin
        if (|w_avail) begin
          w_win       = (&w_avail) ? ~r_last : w_avail[SRC_UART];
          w_pop       = w_win ? 2'b10 : 2'b01;
          w_load      = 1'b1;
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (kbd_rd) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk25) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_kbd_data <= '0;
      r_last     <= 1'(SRC_UART);
      r_ovf      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_kbd_data <= w_out[w_win];
        r_last     <= w_win;
      end
      r_ovf <= (r_ovf & ~{NUM_SRC{ovf_clr}}) | w_ovf_set;
    end
  end

  assign kbd_data  = r_kbd_data;
  assign kbd_ready = (r_state == ST_HOLD);
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_kbd_source_arbiter.sv
// Bench for kbd_source_arbiter: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_kbd_source_arbiter;

  localparam int DEPTH = 4;

  logic       clk25 = 1'b0;
  logic       rst;
  logic [7:0] ps2_data, uart_data;
  logic       ps2_valid, uart_valid;
  logic [1:0] src_en;
  logic       kbd_rd, ovf_clr;
  logic [6:0] kbd_data;
  logic       kbd_ready;
  logic [1:0] ovf;

  int n_checks = 0;
  int n_fail   = 0;

  kbd_source_arbiter #(.FIFO_AW(2)) dut (
    .clk25     (clk25),
    .rst       (rst),
    .ps2_data  (ps2_data),
    .ps2_valid (ps2_valid),
    .uart_data (uart_data),
    .uart_valid(uart_valid),
    .src_en    (src_en),
    .kbd_rd    (kbd_rd),
    .ovf_clr   (ovf_clr),
    .kbd_data  (kbd_data),
    .kbd_ready (kbd_ready),
    .ovf       (ovf)
  );

  always #20 clk25 = ~clk25;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic int fold(input logic [7:0] d);
    int c;
    c = int'(d) & 127;
`ifdef KBD_UPCASE_EN
    if (c >= 97 && c <= 122) c = c - 32;
`endif
    return c;
  endfunction

  // Reference model: character queues, presented char, last-granted source, sticky flags.
  int q_ps2[$];
  int q_uart[$];
  bit m_init  = 1'b0;
  bit m_ready;
  int m_data;
  bit m_last;
  int m_ovf;

  always @(posedge clk25) begin
    bit av0, av1, win;
    int setf;
    if (rst) begin
      q_ps2.delete();
      q_uart.delete();
      m_ready = 1'b0;
      m_data  = 0;
      m_last  = 1'b1;
      m_ovf   = 0;
      m_init  = 1'b1;
    end else if (m_init) begin
      av0 = (q_ps2.size() != 0) && src_en[0];
      av1 = (q_uart.size() != 0) && src_en[1];
      if (m_ready) begin
        if (kbd_rd) m_ready = 1'b0;
      end else if (av0 || av1) begin
        if (av0 && av1) win = !m_last;
        else            win = av1;
        if (win) m_data = q_uart.pop_front();
        else     m_data = q_ps2.pop_front();
        m_ready = 1'b1;
        m_last  = win;
      end
      setf = 0;
      if (!src_en[0]) q_ps2.delete();
      else if (ps2_valid) begin
        if (q_ps2.size() < DEPTH) q_ps2.push_back(fold(ps2_data));
        else setf += 1;
      end
      if (!src_en[1]) q_uart.delete();
      else if (uart_valid) begin
        if (q_uart.size() < DEPTH) q_uart.push_back(fold(uart_data));
        else setf += 2;
      end
      m_ovf = (ovf_clr ? 0 : m_ovf) | setf;
    end
  end

  always @(negedge clk25) begin
    if (m_init) begin
      chk("model_ready", kbd_ready, m_ready);
      chk("model_data",  kbd_data,  m_data);
      chk("model_ovf",   ovf,       m_ovf);
    end
  end

  task automatic step();
    @(posedge clk25);
    #1;
  endtask

  task automatic read_expect(input int exp);
    kbd_rd = 1'b1;
    step();
    kbd_rd = 1'b0;
    step();
    chk("next_ready", kbd_ready, 1);
    chk("next_data",  kbd_data,  exp);
  endtask

  task automatic read_last();
    kbd_rd = 1'b1;
    step();
    kbd_rd = 1'b0;
    step();
  endtask

  task automatic send_ps2(input logic [7:0] d, input int exp);
    ps2_data  = d;
    ps2_valid = 1'b1;
    step();
    ps2_valid = 1'b0;
    step();
    chk("fold_ready", kbd_ready, 1);
    chk("fold_data",  kbd_data,  exp);
    read_last();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ps2_data = '0; uart_data = '0; ps2_valid = 1'b0; uart_valid = 1'b0;
    src_en = 2'b11; kbd_rd = 1'b0; ovf_clr = 1'b0;
    do_reset();
    chk("rst_ready", kbd_ready, 0);
    chk("rst_data",  kbd_data,  0);
    chk("rst_ovf",   ovf,       0);

    // Single key: ready one cycle after the strobe edge.
    ps2_data = 8'h41; ps2_valid = 1'b1;
    step();
    ps2_valid = 1'b0;
    chk("single_notyet", kbd_ready, 0);
    step();
    chk("single_ready", kbd_ready, 1);
    chk("single_data",  kbd_data,  8'h41);
    kbd_rd = 1'b1;
    step();
    kbd_rd = 1'b0;
    chk("single_cleared", kbd_ready, 0);
    chk("single_kept",    kbd_data,  8'h41);

    // Ties: PS/2 first after reset, then alternation continues from the last grant.
    do_reset();
    ps2_data = 8'h31; uart_data = 8'h32; ps2_valid = 1'b1; uart_valid = 1'b1;
    step();
    ps2_valid = 1'b0; uart_valid = 1'b0;
    step();
    chk("tie1_first", kbd_data, 8'h31);
    read_expect(8'h32);
    read_last();
    ps2_data = 8'h33; uart_data = 8'h34; ps2_valid = 1'b1; uart_valid = 1'b1;
    step();
    ps2_valid = 1'b0; uart_valid = 1'b0;
    step();
    chk("tie2_first", kbd_data, 8'h33);
    read_expect(8'h34);
    read_last();
    chk("tie_empty", kbd_ready, 0);

    // Overflow: one presented plus four buffered fit, the sixth byte is dropped.
    for (int k = 0; k < 5; k++) begin
      uart_data = 8'(8'h50 + k); uart_valid = 1'b1;
      step();
    end
    uart_valid = 1'b0;
    chk("ovf_held", kbd_data, 8'h50);
    chk("ovf_none", ovf, 0);
    uart_data = 8'h55; uart_valid = 1'b1;
    step();
    uart_valid = 1'b0;
    chk("ovf_set", ovf, 2'b10);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf_clr", ovf, 0);
    for (int k = 1; k < 5; k++) read_expect(8'h50 + k);
    read_last();
    chk("ovf_drained", kbd_ready, 0);

    // Disable flushes buffered PS/2 bytes and blocks new strobes.
    for (int k = 0; k < 4; k++) begin
      ps2_data = 8'(8'h21 + k); ps2_valid = 1'b1;
      step();
    end
    ps2_valid = 1'b0;
    src_en = 2'b10;
    step();
    ps2_data = 8'h25; ps2_valid = 1'b1;
    step();
    ps2_valid = 1'b0;
    chk("dis_held", kbd_data, 8'h21);
    read_last();
    step();
    chk("dis_empty", kbd_ready, 0);
    src_en = 2'b11;
    step();
    step();
    chk("dis_flushed", kbd_ready, 0);

    // Case folding and bit-7 discard.
`ifdef KBD_UPCASE_EN
    send_ps2(8'h61, 8'h41);
`else
    send_ps2(8'h61, 8'h61);
`endif
    send_ps2(8'h7B, 8'h7B);
    send_ps2(8'hC1, 8'h41);

    // Reset mid-HOLD with both FIFOs loaded.
    for (int k = 0; k < 7; k++) begin
      ps2_data = 8'(8'h10 + k); uart_data = 8'(8'h18 + k);
      ps2_valid = (k < 3); uart_valid = 1'b1;
      step();
    end
    ps2_valid = 1'b0; uart_valid = 1'b0;
    chk("mid_hold", kbd_ready, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_ready", kbd_ready, 0);
    chk("mid_rst_data",  kbd_data,  0);
    chk("mid_rst_ovf",   ovf,       0);
    for (int k = 0; k < 5; k++) step();
    chk("mid_rst_stale", kbd_ready, 0);

    // Randomized traffic against the model.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      ps2_valid  = ($urandom_range(0, 2) == 0);
      uart_valid = ($urandom_range(0, 2) == 0);
      ps2_data   = 8'($urandom);
      uart_data  = 8'($urandom);
      kbd_rd     = ($urandom_range(0, 3) == 0);
      ovf_clr    = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 50) == 0) src_en = 2'($urandom);
      if ($urandom_range(0, 20) == 0) src_en = 2'b11;
      rst        = ($urandom_range(0, 600) == 0);
      step();
    end
    rst = 1'b0; ps2_valid = 1'b0; uart_valid = 1'b0; kbd_rd = 1'b0; ovf_clr = 1'b0;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
